sisc_seq: RTL and testbench

SISC_SEQ -- requirements
Module: sisc_seq

---
 rtl/sisc_seq.sv | 197 +++++++++++++++++++
 tb/tb_sisc_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_seq.sv
// sisc_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional watchdog on the FETCH and MEM wait states, enabled by defining the
// macro SISC_SEQ_TIMEOUT_EN. Without it the sequencer waits indefinitely and
// timeout is tied to 0.
module sisc_seq #(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int BUSY_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic          rf_we,
  output logic          sr_enable,
  output logic          halted,
  output logic          timeout,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU    = 4'h1;
  localparam logic [3:0] OP_LOAD   = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // A watchdog limit below one cycle is meaningless; reject it at elaboration.
  if (BUSY_MAX < 1) begin : g_bad_busy_max
    $error("sisc_seq: BUSY_MAX must be at least 1");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          timeout_q, timeout_d;
  logic [3:0]    opcode_s;
  logic [3:0]    opcode_d_s;

  // Output flags are registered from the next state so they line up with state_q.
  logic imem_req_q, imem_req_d;
  logic dmem_req_q, dmem_req_d;
  logic dmem_we_q, dmem_we_d;
  logic rf_we_q, rf_we_d;
  logic sr_enable_q, sr_enable_d;
  logic halted_q, halted_d;

`ifdef SISC_SEQ_TIMEOUT_EN
  // Counter only ever holds 0..BUSY_MAX-1; reaching the limit halts instead.
  localparam int CW = (BUSY_MAX > 1) ? $clog2(BUSY_MAX) : 1;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          waiting_s;
`endif

  assign opcode_s   = ir_q[DW-1:DW-4];
  assign opcode_d_s = ir_d[DW-1:DW-4];

  // Next-state, pc/ir update and watchdog decision.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode_s)
          OP_ALU:   state_d = S_WB;
          OP_LOAD:  state_d = S_MEM;
          OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            if (br_taken) begin
              pc_d = br_target;
            end else begin
              pc_d = pc_q;
            end
            state_d = S_FETCH;
          end
          OP_HALT:  state_d = S_HALT;
          OP_NOP:   state_d = S_FETCH;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = (opcode_s == OP_LOAD) ? S_WB : S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

`ifdef SISC_SEQ_TIMEOUT_EN
    // A cycle in a wait state without its ack counts; an ack always wins.
    waiting_s = ((state_q == S_FETCH) && !imem_ack) ||
                ((state_q == S_MEM) && !dmem_ack);
    wdog_d    = '0;
    if (waiting_s) begin
      if (wdog_q == CW'(BUSY_MAX - 1)) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + CW'(1);
      end
    end else begin
      wdog_d = '0;
    end
`endif
  end

  // Output flags for the state about to be entered.
  always_comb begin
    imem_req_d  = (state_d == S_FETCH);
    dmem_req_d  = (state_d == S_MEM);
    dmem_we_d   = (state_d == S_MEM) && (opcode_d_s == OP_STORE);
    rf_we_d     = (state_d == S_WB);
    sr_enable_d = (state_d == S_EXEC) && (opcode_d_s == OP_ALU);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      timeout_q   <= 1'b0;
      imem_req_q  <= 1'b1;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      sr_enable_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef SISC_SEQ_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      timeout_q   <= timeout_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      rf_we_q     <= rf_we_d;
      sr_enable_q <= sr_enable_d;
      halted_q    <= halted_d;
`ifdef SISC_SEQ_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // Control outputs are forced low the moment rst_f drops, before any edge.
  assign imem_req  = imem_req_q  & rst_f;
  assign dmem_req  = dmem_req_q  & rst_f;
  assign dmem_we   = dmem_we_q   & rst_f;
  assign rf_we     = rf_we_q     & rst_f;
  assign sr_enable = sr_enable_q & rst_f;
  assign halted    = halted_q    & rst_f;
  assign timeout   = timeout_q   & rst_f;
  assign imem_addr = rst_f ? pc_q : '0;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sisc_seq.sv
// Directed testbench for sisc_seq (AW=16, DW=32, BUSY_MAX=15).
// Observed flag vector: {state, imem_req, dmem_req, dmem_we, rf_we, sr_enable, halted, timeout}.
module tb_sisc_seq;

  logic        clk;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        br_taken;
  logic [15:0] br_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        sr_enable;
  logic        halted;
  logic        timeout;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [2:0]  state;
  logic [9:0]  obs_s;

  int checks = 0;
  int errors = 0;

  sisc_seq #(.AW(16), .DW(32), .BUSY_MAX(15)) dut (
    .clk(clk), .rst_f(rst_f),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .sr_enable(sr_enable), .halted(halted), .timeout(timeout),
    .pc(pc), .ir(ir), .state(state)
  );

  assign obs_s = {state, imem_req, dmem_req, dmem_we, rf_we, sr_enable, halted, timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached: got running need finished");
    $fatal(1);
  end

  task automatic test_reset();
    rst_f = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF; dmem_ack = 1'b1;
    br_taken = 1'b0; br_target = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_s !== {3'd0, 7'b0000000}) begin errors++; $display("FAIL reset_flags got %b need %b", obs_s, {3'd0, 7'b0000000}); end
    checks++;
    if ({pc, ir, imem_addr} !== {16'h0000, 32'h0000_0000, 16'h0000}) begin errors++; $display("FAIL reset_pc_ir got pc=%h ir=%h addr=%h need 0", pc, ir, imem_addr); end
    rst_f = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (obs_s !== {3'd0, 7'b1000000}) begin errors++; $display("FAIL reset_release got %b need %b", obs_s, {3'd0, 7'b1000000}); end
  endtask

  // ALU: F, D, E(sr_enable), WB(rf_we); a stray imem_ack in DECODE is ignored.
  task automatic test_alu();
    logic [9:0] exp_v [0:3];
    exp_v = '{{3'd0, 7'b1000000}, {3'd1, 7'b0000000}, {3'd2, 7'b0000100}, {3'd4, 7'b0001000}};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin errors++; $display("FAIL alu_c%0d got %b need %b", i, obs_s, exp_v[i]); end
      imem_ack  = (i == 0 || i == 1);
      imem_data = (i == 0) ? 32'h1000_0000 : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    checks++;
    if ({obs_s, pc, ir, imem_addr} !== {3'd0, 7'b1000000, 16'h0001, 32'h1000_0000, 16'h0001}) begin
      errors++; $display("FAIL alu_end got flags=%b pc=%h ir=%h addr=%h need flags=0001000000 pc=0001 ir=10000000", obs_s, pc, ir, imem_addr);
    end
  endtask

  // LOAD with dmem_ack three cycles late: 4 cycles of dmem_req, 8 cycles total.
  task automatic test_load();
    logic [9:0] exp_v [0:7];
    logic [7:0] da_m;
    exp_v = '{{3'd0, 7'b1000000}, {3'd1, 7'b0000000}, {3'd2, 7'b0000000}, {3'd3, 7'b0100000},
              {3'd3, 7'b0100000}, {3'd3, 7'b0100000}, {3'd3, 7'b0100000}, {3'd4, 7'b0001000}};
    da_m = 8'b0100_0000;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin errors++; $display("FAIL load_c%0d got %b need %b", i, obs_s, exp_v[i]); end
      imem_ack  = (i == 0);
      imem_data = 32'h2000_0000;
      dmem_ack  = da_m[i];
      @(negedge clk);
    end
    dmem_ack = 1'b0; imem_ack = 1'b0;
    checks++;
    if ({obs_s, pc, ir} !== {3'd0, 7'b1000000, 16'h0002, 32'h2000_0000}) begin
      errors++; $display("FAIL load_end got flags=%b pc=%h ir=%h need flags=0001000000 pc=0002 ir=20000000", obs_s, pc, ir);
    end
  endtask

  // STORE: early dmem_ack in DECODE/EXEC ignored, one MEM wait cycle.
  task automatic test_store();
    logic [9:0] exp_v [0:4];
    logic [4:0] da_m;
    exp_v = '{{3'd0, 7'b1000000}, {3'd1, 7'b0000000}, {3'd2, 7'b0000000}, {3'd3, 7'b0110000}, {3'd3, 7'b0110000}};
    da_m = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin errors++; $display("FAIL store_c%0d got %b need %b", i, obs_s, exp_v[i]); end
      imem_ack  = (i == 0);
      imem_data = 32'h3000_0000;
      dmem_ack  = da_m[i];
      @(negedge clk);
    end
    dmem_ack = 1'b0; imem_ack = 1'b0;
    checks++;
    if ({obs_s, pc, ir} !== {3'd0, 7'b1000000, 16'h0003, 32'h3000_0000}) begin
      errors++; $display("FAIL store_end got flags=%b pc=%h ir=%h need flags=0001000000 pc=0003 ir=30000000", obs_s, pc, ir);
    end
  endtask

  // Back-to-back 3-cycle instructions: branches, pc wrap, NOP, unknown opcode.
  task automatic test_back_to_back();
    logic [31:0] word_v  [0:4];
    logic        tk_v    [0:4];
    logic [15:0] tgt_v   [0:4];
    logic [15:0] addr_v  [0:4];
    logic [9:0]  exp_v   [0:2];
    word_v = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h7ABC_0000};
    tk_v   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tgt_v  = '{16'h0123, 16'h0456, 16'hFFFF, 16'h0777, 16'h0777};
    addr_v = '{16'h0123, 16'h0124, 16'hFFFF, 16'h0000, 16'h0001};
    exp_v  = '{{3'd0, 7'b1000000}, {3'd1, 7'b0000000}, {3'd2, 7'b0000000}};
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_s !== exp_v[i]) begin errors++; $display("FAIL b2b_i%0d_c%0d got %b need %b", j, i, obs_s, exp_v[i]); end
        imem_ack  = (i == 0);
        imem_data = word_v[j];
        br_taken  = tk_v[j];
        br_target = tgt_v[j];
        @(negedge clk);
      end
      imem_ack = 1'b0;
      checks++;
      if ({state, imem_req, imem_addr} !== {3'd0, 1'b1, addr_v[j]}) begin
        errors++; $display("FAIL b2b_i%0d_addr got state=%0d req=%b addr=%h need state=0 req=1 addr=%h", j, state, imem_req, imem_addr, addr_v[j]);
      end
    end
    br_taken = 1'b0;
  endtask

  // HALT holds for 20 cycles ignoring acks; a one-cycle reset returns to FETCH.
  task automatic test_halt();
    logic [9:0] exp_v [0:2];
    exp_v = '{{3'd0, 7'b1000000}, {3'd1, 7'b0000000}, {3'd2, 7'b0000000}};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_s !== exp_v[i]) begin errors++; $display("FAIL halt_c%0d got %b need %b", i, obs_s, exp_v[i]); end
      imem_ack  = (i == 0);
      imem_data = 32'hF000_0000;
      @(negedge clk);
    end
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_data = 32'h1000_0000;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs_s !== {3'd5, 7'b0000010}) begin errors++; $display("FAIL halt_hold_c%0d got %b need %b", i, obs_s, {3'd5, 7'b0000010}); end
      @(negedge clk);
    end
    rst_f = 1'b0;
    #1;
    checks++;
    if (obs_s !== {3'd5, 7'b0000000}) begin errors++; $display("FAIL halt_rst_gate got %b need %b", obs_s, {3'd5, 7'b0000000}); end
    @(negedge clk);
    checks++;
    if ({state, pc, ir} !== {3'd0, 16'h0000, 32'h0000_0000}) begin
      errors++; $display("FAIL halt_rst_state got state=%0d pc=%h ir=%h need state=0 pc=0000 ir=00000000", state, pc, ir);
    end
    rst_f = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if ({obs_s, imem_addr} !== {3'd0, 7'b1000000, 16'h0000}) begin
      errors++; $display("FAIL halt_release got flags=%b addr=%h need flags=0001000000 addr=0000", obs_s, imem_addr);
    end
  endtask

  task automatic test_timeout();
`ifdef SISC_SEQ_TIMEOUT_EN
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (obs_s !== {3'd0, 7'b1000000}) begin errors++; $display("FAIL to_wait_c%0d got %b need %b", i, obs_s, {3'd0, 7'b1000000}); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_s !== {3'd5, 7'b0000011}) begin errors++; $display("FAIL to_fired_c%0d got %b need %b", i, obs_s, {3'd5, 7'b0000011}); end
      @(negedge clk);
    end
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    checks++;
    if (obs_s !== {3'd0, 7'b1000000}) begin errors++; $display("FAIL to_reset got %b need %b", obs_s, {3'd0, 7'b1000000}); end
    for (int i = 0; i < 15; i++) begin
      imem_ack  = (i == 14);
      imem_data = 32'h0000_0000;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    checks++;
    if (obs_s !== {3'd1, 7'b0000000}) begin errors++; $display("FAIL to_ack_wins got %b need %b", obs_s, {3'd1, 7'b0000000}); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_s !== {3'd0, 7'b1000000}) begin errors++; $display("FAIL to_ack_back got %b need %b", obs_s, {3'd0, 7'b1000000}); end
`else
    imem_ack = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (obs_s !== {3'd0, 7'b1000000}) begin errors++; $display("FAIL no_to_wait got %b need %b", obs_s, {3'd0, 7'b1000000}); end
    imem_ack = 1'b1; imem_data = 32'h0000_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({obs_s, pc} !== {3'd1, 7'b0000000, 16'h0001}) begin errors++; $display("FAIL no_to_fetch got flags=%b pc=%h need flags=0010000000 pc=0001", obs_s, pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_halt();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
